fetch_buffer: RTL

Instruction fetch buffer that sits in front of the decoder and supplies it with instructions. It issues aligned 64-bit fetch requests to instruction memory, queues the returned instructions with their PCs in a circular buffer, and presents up to two in-order instructions per cycle to the decode stage. It also handles front-end redirects (branch/jump/flush) and discards stale in-flight responses.

---
 rtl/fetch_buffer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: issues aligned 64-bit fetches, queues returned
// instructions with their PCs and presents the two oldest to decode.
module fetch_buffer #(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_valid_i,
  input  logic [63:0] imem_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] inst0_o,
  output logic [31:0] inst1_o,
  output logic [31:0] pc0_o,
  output logic [31:0] pc1_o,
  output logic [1:0]  valid_o,
  input  logic [1:0]  take_i
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW+1:0] REQ_LIMIT = (PW+2)'(DEPTH - 2);

  logic [31:0] inst_mem [DEPTH];
  logic [31:0] pc_mem   [DEPTH];

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          skip_lo_q, skip_lo_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          inflight_q, inflight_d;
  logic          drop_q, drop_d;
  logic          req_skip_q, req_skip_d;
  logic [31:0]   req_addr_q, req_addr_d;

  logic [PW+1:0] used;
  logic          req;
  logic          resp_ok;
  logic [1:0]    n_wr;
  logic          wr_lo_en;
  logic          wr_hi_en;
  logic [PW-1:0] wr_hi_idx;
  logic [PW-1:0] rd_ptr_p1;
  logic [1:0]    unused_pc_bits;

  assign unused_pc_bits = redirect_pc_i[1:0];

  // The in-flight request is charged two slots so a full queue cannot overflow.
  assign used     = {1'b0, count_q} + (inflight_q ? (PW+2)'(2) : (PW+2)'(0));
  assign req      = !rst_i && !redirect_i && (used <= REQ_LIMIT);
  assign resp_ok  = imem_valid_i && !drop_q && !redirect_i;
  assign n_wr     = resp_ok ? (req_skip_q ? 2'd1 : 2'd2) : 2'd0;
  assign wr_lo_en = resp_ok && !req_skip_q;
  assign wr_hi_en = resp_ok;
  assign wr_hi_idx = req_skip_q ? wr_ptr_q : wr_ptr_q + PW'(1);
  assign rd_ptr_p1 = rd_ptr_q + PW'(1);

  assign imem_req_o  = req;
  assign imem_addr_o = fetch_pc_q;
  assign valid_o     = {count_q >= (PW+1)'(2), count_q >= (PW+1)'(1)};
  assign inst0_o     = inst_mem[rd_ptr_q];
  assign pc0_o       = pc_mem[rd_ptr_q];
  assign inst1_o     = inst_mem[rd_ptr_p1];
  assign pc1_o       = pc_mem[rd_ptr_p1];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    skip_lo_d  = skip_lo_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    req_skip_d = req_skip_q;
    req_addr_d = req_addr_q;

    if (req) begin
      fetch_pc_d = fetch_pc_q + 32'd8;
      skip_lo_d  = 1'b0;
      req_skip_d = skip_lo_q;
      req_addr_d = fetch_pc_q;
      inflight_d = 1'b1;
    end else if (imem_valid_i) begin
      inflight_d = 1'b0;
    end

    if (imem_valid_i) begin
      drop_d = 1'b0;
    end

    if (redirect_i) begin
      count_d    = '0;
      rd_ptr_d   = wr_ptr_q;
      fetch_pc_d = {redirect_pc_i[31:3], 3'b000};
      skip_lo_d  = redirect_pc_i[2];
      // A response landing in this very cycle is already ignored; only a
      // still-pending one needs to be dropped later.
      drop_d     = inflight_q && !imem_valid_i;
    end else begin
      rd_ptr_d = rd_ptr_q + PW'(take_i);
      wr_ptr_d = wr_ptr_q + PW'(n_wr);
      count_d  = count_q + (PW+1)'(n_wr) - (PW+1)'(take_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc_q <= {RESET_PC[31:3], 3'b000};
      skip_lo_q  <= RESET_PC[2];
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
      req_skip_q <= 1'b0;
      req_addr_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      skip_lo_q  <= skip_lo_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      req_skip_q <= req_skip_d;
      req_addr_q <= req_addr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_lo_en) begin
      inst_mem[wr_ptr_q] <= imem_data_i[31:0];
      pc_mem[wr_ptr_q]   <= req_addr_q;
    end
    if (wr_hi_en) begin
      inst_mem[wr_hi_idx] <= imem_data_i[63:32];
      pc_mem[wr_hi_idx]   <= req_addr_q + 32'd4;
    end
  end

endmodule
